// File: rtl/ifu_pc_gen_if.sv
// Fetch-side bundle: bpu lookup, imem request/response, decode delivery, exu redirect.
// Latency: none, pure wiring.
// Backpressure: carries imem_req_ready and inst_ready from the consumers back to fetch.
interface ifu_pc_gen_if #(
    parameter int N_ADDR_W = 3
);
    logic                bp_req_valid;
    logic                bp_req_ready;
    logic [31:0]         bp_req_pc;
    logic                bp_resp_valid;
    logic                bp_resp_match;
    logic [N_ADDR_W-1:0] bp_resp_addr;
    logic [31:0]         bp_resp_pc;
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [31:0]         imem_req_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst;
    logic [31:0]         inst_pc;
    logic                inst_bp_taken;
    logic                inst_bp_match;
    logic [N_ADDR_W-1:0] inst_bp_addr;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;

    // Fetch-unit side
    modport master (
        output bp_req_valid, bp_req_pc, imem_req_valid, imem_req_addr,
               inst_valid, inst, inst_pc, inst_bp_taken, inst_bp_match, inst_bp_addr,
        input  bp_req_ready, bp_resp_valid, bp_resp_match, bp_resp_addr, bp_resp_pc,
               imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    // Environment side (bpu, imem, decode, exu)
    modport slave (
        input  bp_req_valid, bp_req_pc, imem_req_valid, imem_req_addr,
               inst_valid, inst, inst_pc, inst_bp_taken, inst_bp_match, inst_bp_addr,
        output bp_req_ready, bp_resp_valid, bp_resp_match, bp_resp_addr, bp_resp_pc,
               imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: bpu lookup + in-order imem issue + metadata queue + output instruction FIFO.
// Latency: request at N, response at N+k, inst_valid at N+k+1; taken prediction steers the very next request.
// Backpressure: credits (outstanding + buffered <= FQ_DEPTH) stall issue; redirect flushes and drains stale responses.
module ifu_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          N_ADDR_W = 3,
    parameter int          FQ_DEPTH = 4
) (
    input logic           clk,
    input logic           rstn,
    ifu_pc_gen_if.master  bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0]         pc;
        logic                taken;
        logic                match;
        logic [N_ADDR_W-1:0] addr;
    } meta_t;

    typedef struct packed {
        meta_t       meta;
        logic [31:0] data;
    } inst_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] buf_count_q, buf_count_d;
    logic [PTR_W-1:0] mq_wr_q, mq_wr_d, mq_rd_q, mq_rd_d;
    logic [PTR_W-1:0] ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;
    meta_t            mq_mem_q [FQ_DEPTH];
    meta_t            mq_mem_d [FQ_DEPTH];
    inst_t            ob_mem_q [FQ_DEPTH];
    inst_t            ob_mem_d [FQ_DEPTH];

    logic        credit_ok, issue, hs, resp, redir, drop, ob_push, ob_pop;
    logic [31:0] next_pc, redir_pc;
    meta_t       push_meta;
    inst_t       push_inst;
    logic        unused_bp_req_ready;

    // The predictor never stalls, so its ready is deliberately not consulted.
    assign unused_bp_req_ready = bus.bp_req_ready;

    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count_q}) < (CNT_W + 1)'(FQ_DEPTH);
    assign issue     = (state_q == RUN) && !bus.redirect_valid && credit_ok;
    assign hs        = issue && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol violation; ignore it.
    assign resp      = bus.imem_resp_valid && (outstanding_q != '0);
    assign redir     = bus.redirect_valid && (state_q != BOOT);
    // Responses are dropped on the redirect cycle itself and while draining stale fetches.
    assign drop      = redir || (state_q == DRAIN);
    assign ob_push   = resp && !drop;
    assign ob_pop    = bus.inst_valid && bus.inst_ready;
    assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};
    assign next_pc   = bus.bp_resp_valid ? {bus.bp_resp_pc[31:2], 2'b00} : pc_q + 32'd4;

    assign push_meta = '{pc: pc_q, taken: bus.bp_resp_valid, match: bus.bp_resp_match,
                         addr: bus.bp_resp_addr};
    assign push_inst = '{meta: mq_mem_q[mq_rd_q], data: bus.imem_resp_data};

    assign bus.bp_req_valid   = issue;
    assign bus.bp_req_pc      = pc_q;
    assign bus.imem_req_valid = issue;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (buf_count_q != '0) && !bus.redirect_valid;
    assign bus.inst           = ob_mem_q[ob_rd_q].data;
    assign bus.inst_pc        = ob_mem_q[ob_rd_q].meta.pc;
    assign bus.inst_bp_taken  = ob_mem_q[ob_rd_q].meta.taken;
    assign bus.inst_bp_match  = ob_mem_q[ob_rd_q].meta.match;
    assign bus.inst_bp_addr   = ob_mem_q[ob_rd_q].meta.addr;

    // Next-state: FSM, PC, credit counters, metadata queue and output FIFO.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        outstanding_d = outstanding_q + CNT_W'(hs) - CNT_W'(resp);
        mq_wr_d       = mq_wr_q;
        mq_rd_d       = mq_rd_q;
        mq_mem_d      = mq_mem_q;
        ob_wr_d       = ob_wr_q;
        ob_rd_d       = ob_rd_q;
        ob_mem_d      = ob_mem_q;
        buf_count_d   = buf_count_q + CNT_W'(ob_push) - CNT_W'(ob_pop);

        if (hs) begin
            mq_mem_d[mq_wr_q] = push_meta;
            mq_wr_d           = mq_wr_q + PTR_W'(1);
        end
        if (resp) begin
            mq_rd_d = mq_rd_q + PTR_W'(1);
        end
        if (ob_push) begin
            ob_mem_d[ob_wr_q] = push_inst;
            ob_wr_d           = ob_wr_q + PTR_W'(1);
        end
        if (ob_pop) begin
            ob_rd_d = ob_rd_q + PTR_W'(1);
        end
        if (redir) begin
            ob_wr_d     = '0;
            ob_rd_d     = '0;
            buf_count_d = '0;
        end

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (bus.redirect_valid) pc_d = redir_pc;
            end
            RUN: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    kill_d  = outstanding_q - CNT_W'(resp);
                    state_d = (kill_d != '0) ? DRAIN : RUN;
                end else if (hs) begin
                    pc_d = next_pc;
                end
            end
            DRAIN: begin
                if (redir) pc_d = redir_pc;
                if (resp && (kill_q != '0)) kill_d = kill_q - CNT_W'(1);
                state_d = (kill_d == '0) ? RUN : DRAIN;
            end
            default: state_d = BOOT;
        endcase
    end

    // All fetch state, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            kill_q        <= '0;
            outstanding_q <= '0;
            buf_count_q   <= '0;
            mq_wr_q       <= '0;
            mq_rd_q       <= '0;
            ob_wr_q       <= '0;
            ob_rd_q       <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mq_mem_q[i] <= '0;
                ob_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            outstanding_q <= outstanding_d;
            buf_count_q   <= buf_count_d;
            mq_wr_q       <= mq_wr_d;
            mq_rd_q       <= mq_rd_d;
            ob_wr_q       <= ob_wr_d;
            ob_rd_q       <= ob_rd_d;
            mq_mem_q      <= mq_mem_d;
            ob_mem_q      <= ob_mem_d;
        end
    end
endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed bench for ifu_pc_gen with a queue-based scoreboard of expected instructions.
// Latency: imem model answers one cycle after acceptance unless responses are held.
// Backpressure: steps toggle imem_req_ready / inst_ready and inject redirects.
module tb_ifu_pc_gen;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_ADDR_W = 3;
    localparam int          FQ_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        match;
        logic [2:0]  addr;
    } ent_t;

    typedef struct packed {
        ent_t        m;
        logic [31:0] data;
    } inst_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifu_pc_gen_if #(.N_ADDR_W(N_ADDR_W)) bus ();

    ifu_pc_gen #(.RESET_PC(RESET_PC), .N_ADDR_W(N_ADDR_W), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Combinational bpu model: a single configurable taken-branch entry.
    logic        hit_en = 1'b0;
    logic [31:0] hit_pc = 32'h0;
    logic [31:0] hit_tgt = 32'h0;
    logic [2:0]  hit_idx = 3'd0;
    assign bus.bp_resp_match = hit_en && (bus.bp_req_pc == hit_pc);
    assign bus.bp_resp_valid = bus.bp_resp_match;
    assign bus.bp_resp_addr  = bus.bp_resp_match ? hit_idx : 3'd0;
    assign bus.bp_resp_pc    = hit_tgt;

    ent_t        pend[$];     // accepted requests awaiting a memory response
    inst_t       sb[$];       // instructions expected from decode port, in order
    logic [31:0] obs_log[$];  // addresses the DUT actually handed to memory
    int          errors = 0;
    int          checks = 0;
    int          tb_state = 0;  // 0 boot, 1 run, 2 drain
    int          kill = 0;
    logic [31:0] exp_pc = RESET_PC;
    bit          resp_en = 1'b1;
    bit          seen_hit8 = 1'b0;
    int          n_acc = 0;
    int          n_inst = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t predict(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.match = hit_en && (pc == hit_pc);
        e.taken = e.match;
        e.addr  = e.match ? hit_idx : 3'd0;
        return e;
    endfunction

    // One clock: drive memory response, check at negedge, advance the expectation model.
    task automatic tick();
        ent_t  e;
        inst_t want;
        inst_t got;
        bit    ev_req, ev_inst, r, redir, drop, hs;
        int    out0;
        if (resp_en && pend.size() > 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = pend[0].pc ^ 32'hDEAD_BEEF;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        @(negedge clk);
        redir   = bus.redirect_valid && (tb_state != 0);
        ev_req  = (tb_state == 1) && !bus.redirect_valid && (pend.size() + sb.size() < FQ_DEPTH);
        ev_inst = (sb.size() != 0) && !bus.redirect_valid;
        chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(ev_req));
        chk("bp_req_valid", 32'(bus.bp_req_valid), 32'(ev_req));
        chk("inst_valid", 32'(bus.inst_valid), 32'(ev_inst));
        if (ev_req) begin
            chk("imem_req_addr", bus.imem_req_addr, exp_pc);
            chk("bp_req_pc", bus.bp_req_pc, exp_pc);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            obs_log.push_back(bus.imem_req_addr);
            n_acc++;
        end
        if (ev_inst && bus.inst_ready) begin
            want = sb.pop_front();
            chk("inst", bus.inst, want.data);
            chk("inst_pc", bus.inst_pc, want.m.pc);
            chk("inst_meta", 32'({bus.inst_bp_taken, bus.inst_bp_match, bus.inst_bp_addr}),
                32'({want.m.taken, want.m.match, want.m.addr}));
            if (want.m.pc == 32'h8 && want.m.taken) seen_hit8 = 1'b1;
            n_inst++;
        end
        hs   = ev_req && bus.imem_req_ready;
        r    = bus.imem_resp_valid && (pend.size() > 0);
        drop = redir || (tb_state == 2);
        out0 = pend.size();
        if (r) begin
            e = pend.pop_front();
            if (!drop) begin
                got.m    = e;
                got.data = bus.imem_resp_data;
                sb.push_back(got);
            end
        end
        if (redir) sb.delete();
        if (hs) begin
            e = predict(exp_pc);
            pend.push_back(e);
            exp_pc = e.taken ? {hit_tgt[31:2], 2'b00} : exp_pc + 32'd4;
        end
        case (tb_state)
            0: begin
                tb_state = 1;
                if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end
            1: if (redir) begin
                kill     = out0 - int'(r);
                exp_pc   = {bus.redirect_pc[31:2], 2'b00};
                tb_state = (kill > 0) ? 2 : 1;
            end
            default: begin
                kill = kill - int'(r);
                if (redir) exp_pc = {bus.redirect_pc[31:2], 2'b00};
                tb_state = (kill == 0) ? 1 : 2;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pend.delete();
        sb.delete();
        tb_state = 0;
        kill     = 0;
        exp_pc   = RESET_PC;
    endtask

    initial begin
        int n0;
        int n1;
        bus.bp_req_ready    = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready      = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_bp_req_pc", bus.bp_req_pc, RESET_PC);
        chk("rst_imem_req_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();

        // Streaming, no prediction, one-cycle memory
        repeat (12) tick();
        chk("seq0", obs_log[0], 32'h0);
        chk("seq1", obs_log[1], 32'h4);
        chk("seq2", obs_log[2], 32'h8);
        chk("seq3", obs_log[3], 32'hC);
        n0 = n_inst;
        repeat (6) tick();
        chk("stream_rate", 32'(n_inst - n0), 32'd6);

        // Taken branch at 0x8 -> 0x100, entry 2
        hit_en = 1'b1; hit_pc = 32'h8; hit_tgt = 32'h100; hit_idx = 3'd2;
        obs_log.delete();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (10) tick();
        chk("hit_pc8", obs_log[2], 32'h8);
        chk("hit_next", obs_log[3], 32'h100);
        chk("hit_next2", obs_log[4], 32'h104);
        chk("hit_meta_seen", 32'(seen_hit8), 32'h1);
        hit_en = 1'b0;

        // Decode stall: credits cap the requests at FQ_DEPTH
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1;
        n0 = n_acc;
        repeat (10) tick();
        chk("credit_accepts", 32'(n_acc - n0), 32'd4);
        n1 = n_acc;
        bus.inst_ready = 1'b1;
        repeat (10) tick();
        chk("resume_after_stall", 32'(n_acc > n1), 32'h1);

        // Redirect with 2 outstanding, coinciding with one response
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        resp_en = 1'b0; bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        bus.imem_req_ready = 1'b0;
        chk("two_outstanding", 32'(pend.size()), 32'd2);
        resp_en = 1'b1; bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
        obs_log.delete();
        n0 = n_inst;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("drain_no_issue", 32'(obs_log.size()), 32'd0);
        chk("no_stale_inst", 32'(n_inst - n0), 32'd0);
        repeat (4) tick();
        chk("redir_first_addr", obs_log[0], 32'h200);

        // Second redirect while draining wins
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        resp_en = 1'b0; bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
        tick();
        resp_en = 1'b1;
        bus.redirect_pc = 32'h300;
        tick();
        bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
        obs_log.delete();
        repeat (5) tick();
        chk("redir2_first_addr", obs_log[0], 32'h300);

        // Wrap at the top of the address space; low redirect bits forced to 0
        obs_log.delete();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (5) tick();
        chk("wrap_top", obs_log[0], 32'hFFFF_FFFC);
        chk("wrap_zero", obs_log[1], 32'h0);

        // Reset in mid-operation
        rstn = 1'b0;
        bus.imem_resp_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("mid_rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("mid_rst_pc", bus.bp_req_pc, RESET_PC);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        obs_log.delete();
        repeat (8) tick();
        chk("post_rst_first_addr", obs_log[0], RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
